fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 26 ++
 rtl/fifo_rd_stream.sv | 78 +++++++
 tb/tb_fifo_rd_stream.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Stream bundle between sync_fifo read port, fifo_rd_stream and consumer.
// master: the reader block; slave: the FIFO/consumer side (testbench).
interface fifo_rd_stream_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] drain_cnt;
    logic             busy;

    modport master (
        input  enable, fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data, drain_cnt, busy
    );

    modport slave (
        output enable, fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, drain_cnt, busy
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Pops a 1-cycle-latency sync_fifo into a 2-entry valid/ready stream.
// Ports: clk, rst_n (async low), strm (master: FIFO pop side + stream out).
module fifo_rd_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_rd_stream_if.master  strm
);

    logic [1:0]       occ_q, occ_d;
    logic             infl_q;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic [1:0]       room;

    assign accept = (occ_q != 2'd0) & strm.out_ready;

    // Slots committed after this edge; occ+inflight never exceeds 2,
    // and accept implies occ>=1, so this cannot underflow.
    assign room = occ_q + {1'b0, infl_q} - {1'b0, accept};

    assign strm.fifo_rd_en = rst_n & strm.enable & ~strm.fifo_empty
                           & (room <= 2'd1);

    assign strm.out_valid = (occ_q != 2'd0);
    assign strm.out_data  = buf_q[0];
    assign strm.drain_cnt = cnt_q;
    assign strm.busy      = (occ_q != 2'd0) | infl_q;

    // buf_q[0] is always the head; entries shift down on a pop.
    always_comb begin
        occ_d    = occ_q;
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        case ({infl_q, accept})
            2'b01: begin
                buf_d[0] = buf_q[1];
                occ_d    = occ_q - 2'd1;
            end
            2'b10: begin
                buf_d[occ_q[0]] = strm.fifo_rd_data;
                occ_d           = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf_d[0] = strm.fifo_rd_data;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = strm.fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            cnt_q    <= '0;
        end else begin
            occ_q    <= occ_d;
            infl_q   <= strm.fifo_rd_en;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural sync_fifo model plus scoreboard.
// Drives after posedge+1, samples the stream on the negative edge.
module tb_fifo_rd_stream;

    localparam int W = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fifo_rd_stream_if #(.WIDTH(W), .CNT_W(CW)) s ();

    fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .strm  (s)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fq [$];
    logic [W-1:0] exp_q [$];
    int xfer_cyc [$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pops = 0;
    int xfers = 0;
    int first_pop = -1;
    int base;
    int rel_cyc;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push(logic [W-1:0] v);
        fq.push_back(v);
        s.fifo_empty = 1'b0;
    endtask

    task automatic tick();
        logic pop;
        logic acc;
        @(negedge clk);
        pop = s.fifo_rd_en;
        acc = s.out_valid & s.out_ready;
        if (pop) begin
            check("no_underflow", 32'(fq.size() == 0), 0);
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (acc) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                check("data", 32'(s.out_data), 32'(exp_q.pop_front()));
            xfer_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && fq.size() != 0) begin
            s.fifo_rd_data = fq.pop_front();
            exp_q.push_back(s.fifo_rd_data);
        end
        s.fifo_empty = (fq.size() == 0);
        if (acc) begin
            xfers++;
            check("drain_cnt", 32'(s.drain_cnt), 32'(xfers[CW-1:0]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(s.out_valid), 0);
        check("rst_busy", 32'(s.busy), 0);
        check("rst_drain", 32'(s.drain_cnt), 0);
        check("rst_rd_en", 32'(s.fifo_rd_en), 0);
        check("rst_data", 32'(s.out_data), 0);
        fq.delete();
        exp_q.delete();
        s.fifo_rd_data = '0;
        s.fifo_empty = 1'b1;
        xfers = 0;
        tick();
        tick();
    endtask

    initial begin
        s.enable = 1'b1;
        s.out_ready = 1'b1;
        s.fifo_empty = 1'b1;
        s.fifo_rd_data = '0;
        @(posedge clk);
        #1;
        do_reset();
        rst_n = 1'b1;

        // empty FIFO: no pops for 20 cycles
        pops = 0;
        for (int i = 0; i < 20; i++) tick();
        check("empty_pops", 32'(pops), 0);
        check("empty_valid", 32'(s.out_valid), 0);
        check("empty_drain", 32'(s.drain_cnt), 0);

        // streaming 4,3,2,1,1,0 at full rate
        first_pop = -1;
        xfer_cyc.delete();
        push(4); push(3); push(2); push(1); push(1); push(0);
        for (int i = 0; i < 20; i++) tick();
        check("strm_count", 32'(xfer_cyc.size()), 6);
        for (int i = 0; i < xfer_cyc.size() && i < 6; i++)
            check("strm_cycle", 32'(xfer_cyc[i]),
                  32'(first_pop + 2 + i));
        check("strm_drain", 32'(s.drain_cnt), 6);
        check("strm_busy", 32'(s.busy), 0);

        // backpressure 4,5,7
        s.out_ready = 1'b0;
        pops = 0;
        push(4); push(5); push(7);
        for (int i = 0; i < 8; i++) tick();
        check("bp_pops", 32'(pops), 2);
        check("bp_valid", 32'(s.out_valid), 1);
        check("bp_hold", 32'(s.out_data), 4);
        check("bp_left", 32'(fq.size()), 1);
        s.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("bp_pops_all", 32'(pops), 3);
        check("bp_sb_done", 32'(exp_q.size()), 0);
        check("bp_busy", 32'(s.busy), 0);

        // enable dropped right after the 2nd pop
        pops = 0;
        base = xfers;
        push(9); push(10); push(11); push(12);
        for (int i = 0; i < 10 && pops < 2; i++) tick();
        s.enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("en_pops", 32'(pops), 2);
        check("en_left", 32'(fq.size()), 2);
        check("en_deliv", 32'(xfers - base), 2);
        check("en_busy", 32'(s.busy), 0);

        // reset mid-stream with words buffered and in flight
        s.out_ready = 1'b0;
        push(13);
        s.enable = 1'b1;
        tick();
        tick();
        check("mid_busy", 32'(s.busy), 1);
        check("mid_valid", 32'(s.out_valid), 1);
        do_reset();
        first_pop = -1;
        s.out_ready = 1'b1;
        push(6); push(2); push(15);
        rel_cyc = cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rst_first_pop", 32'(first_pop), 32'(rel_cyc));
        check("rst_xfers", 32'(xfers), 3);
        check("rst_sb_done", 32'(exp_q.size()), 0);
        check("rst_busy_end", 32'(s.busy), 0);

        // counter wrap: 17 transfers on a 4-bit counter
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) push(W'($urandom_range(0, 15)));
        for (int i = 0; i < 25; i++) tick();
        check("wrap_xfers", 32'(xfers), 17);
        check("wrap_drain", 32'(s.drain_cnt), 1);
        check("wrap_sb_done", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
